audio_cue_sequencer: RTL and testbench

- Controller for the Pmod amplifier audio path: plays fixed note sequences ("shuffle" cue, "solve" cue) by driving the square-wave tone generator's half-period and enable inputs and the amplifier's shutdown/gain pins.
- Arbitrates between the shuffle and solve requesters in the game FSM; solve has priority.
- Sits between the game state logic and the tone generator feeding audio_out.

---
 rtl/audio_cue_sequencer.sv | 168 ++++++++++++++++
 tb/tb_audio_cue_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/audio_cue_sequencer.sv
// Cue sequencer for the Pmod amp: wakes the amplifier, plays the shuffle
// or solve melody through the tone generator and signals completion.
module audio_cue_sequencer #(
    parameter int unsigned TICK_DIV   = 100000,
    parameter int unsigned WAKE_TICKS = 5,
    parameter int unsigned NOTE_TICKS = 150,
    parameter int unsigned GAP_TICKS  = 20,
    parameter bit          GAIN_HIGH  = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        shuffle_req,
    input  logic        solve_req,
    output logic [17:0] tone_half_period,
    output logic        tone_en,
    output logic        amp_shdn,
    output logic        amp_gain,
    output logic        busy,
    output logic        done
);

    localparam int PW = $clog2(TICK_DIV + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAKE, S_NOTE, S_GAP, S_DONE
    } state_t;

    state_t        state_q;
    logic [PW-1:0] pre_q;
    logic [15:0]   tick_q;
    logic [1:0]    idx_q;
    logic          mel_q;
    logic          shuf_q;
    logic          solv_q;

    logic [15:0]   len;
    logic          pre_wrap;
    logic          tick_end;
    logic          preempt;
    logic [1:0]    last_idx;

    // Solve melody extends the shuffle melody, so one table serves both.
    function automatic logic [17:0] rom(input logic [1:0] i);
        case (i)
            2'd0:    rom = 18'd95556;
            2'd1:    rom = 18'd75843;
            2'd2:    rom = 18'd63776;
            default: rom = 18'd47778;
        endcase
    endfunction

    always_comb begin
        len = 16'd1;
        case (state_q)
            S_WAKE:  len = 16'(WAKE_TICKS);
            S_NOTE:  len = 16'(NOTE_TICKS);
            S_GAP:   len = 16'(GAP_TICKS);
            default: len = 16'd1;
        endcase
        pre_wrap = (pre_q == PW'(TICK_DIV - 1));
        tick_end = pre_wrap && (tick_q == len - 16'd1);
        preempt  = solv_q && !mel_q;
        last_idx = mel_q ? 2'd3 : 2'd2;
    end

    assign amp_gain = GAIN_HIGH;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            pre_q            <= '0;
            tick_q           <= '0;
            idx_q            <= '0;
            mel_q            <= 1'b0;
            shuf_q           <= 1'b0;
            solv_q           <= 1'b0;
            tone_half_period <= '0;
            tone_en          <= 1'b0;
            amp_shdn         <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
        end else begin
            shuf_q <= enable && shuffle_req;
            solv_q <= enable && solve_req;
            done   <= 1'b0;
            if (pre_wrap) begin
                pre_q  <= '0;
                tick_q <= tick_q + 16'd1;
            end else begin
                pre_q <= pre_q + PW'(1);
            end
            if (!enable) begin
                state_q          <= S_IDLE;
                pre_q            <= '0;
                tick_q           <= '0;
                idx_q            <= '0;
                mel_q            <= 1'b0;
                tone_half_period <= '0;
                tone_en          <= 1'b0;
                amp_shdn         <= 1'b0;
                busy             <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        pre_q  <= '0;
                        tick_q <= '0;
                        if (solv_q || shuf_q) begin
                            state_q  <= S_WAKE;
                            mel_q    <= solv_q;
                            busy     <= 1'b1;
                            amp_shdn <= 1'b1;
                        end
                    end
                    S_WAKE: begin
                        // Preempting during wake keeps the wake timing.
                        if (preempt) mel_q <= 1'b1;
                        if (tick_end) begin
                            state_q          <= S_NOTE;
                            idx_q            <= 2'd0;
                            tone_en          <= 1'b1;
                            tone_half_period <= rom(2'd0);
                            pre_q            <= '0;
                            tick_q           <= '0;
                        end
                    end
                    S_NOTE, S_GAP: begin
                        if (preempt) begin
                            state_q          <= S_NOTE;
                            mel_q            <= 1'b1;
                            idx_q            <= 2'd0;
                            tone_en          <= 1'b1;
                            tone_half_period <= rom(2'd0);
                            pre_q            <= '0;
                            tick_q           <= '0;
                        end else if (tick_end) begin
                            pre_q  <= '0;
                            tick_q <= '0;
                            if (state_q == S_NOTE) begin
                                state_q <= S_GAP;
                                tone_en <= 1'b0;
                            end else if (idx_q == last_idx) begin
                                state_q <= S_DONE;
                                done    <= 1'b1;
                            end else begin
                                state_q          <= S_NOTE;
                                idx_q            <= idx_q + 2'd1;
                                tone_en          <= 1'b1;
                                tone_half_period <= rom(idx_q + 2'd1);
                            end
                        end
                    end
                    default: begin
                        state_q          <= S_IDLE;
                        pre_q            <= '0;
                        tick_q           <= '0;
                        idx_q            <= '0;
                        mel_q            <= 1'b0;
                        tone_half_period <= '0;
                        amp_shdn         <= 1'b0;
                        busy             <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_audio_cue_sequencer.sv
// Bench for audio_cue_sequencer: directed cue scenarios then random
// requests/enable toggles, compared against a timeline model every cycle.
module tb_audio_cue_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        shr = 1'b0;
    logic        sor = 1'b0;
    logic [17:0] half;
    logic        ten, shdn, gain, busy, done;

    audio_cue_sequencer #(
        .TICK_DIV(4), .WAKE_TICKS(2), .NOTE_TICKS(3),
        .GAP_TICKS(1), .GAIN_HIGH(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .shuffle_req(shr), .solve_req(sor),
        .tone_half_period(half), .tone_en(ten),
        .amp_shdn(shdn), .amp_gain(gain),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total = 0;
    int cyc = 0;

    // Model: a cue is (start cycle of wake, melody); everything else
    // follows from 8-cycle wake and 16-cycle note pitch (12 on, 4 off).
    bit act = 0;
    int s = 0;
    bit mel = 0;
    bit p_sh = 0;
    bit p_so = 0;

    function automatic int mlen(bit m);
        return m ? 4 : 3;
    endfunction

    function automatic int note_hp(int i);
        case (i)
            0: return 95556;
            1: return 75843;
            2: return 63776;
            default: return 47778;
        endcase
    endfunction

    task automatic chk(string tag, int obs, int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s cyc=%0d observed=%0d expected=%0d",
                    tag, cyc, obs, exp);
    endtask

    task automatic model_edge(int c);
        int o1, L;
        if (!enable) begin
            act = 0; p_sh = 0; p_so = 0;
        end else begin
            if (!act) begin
                if (p_so || p_sh) begin
                    act = 1; s = c; mel = p_so;
                end
            end else begin
                o1 = c - 1 - s;
                L = mlen(mel);
                if (o1 == 8 + 16 * L) act = 0;
                else if (p_so && !mel) begin
                    if (o1 >= 8) s = c - 8;
                    mel = 1;
                end
            end
            p_sh = shr; p_so = sor;
        end
    endtask

    task automatic check_all();
        int o, L, n, w;
        int e_busy, e_shdn, e_ten, e_done, e_half;
        e_busy = 0; e_shdn = 0; e_ten = 0; e_done = 0; e_half = 0;
        if (act) begin
            o = cyc - s;
            L = mlen(mel);
            e_busy = 1; e_shdn = 1;
            if (o >= 8 && o < 8 + 16 * L) begin
                n = (o - 8) / 16;
                w = (o - 8) % 16;
                e_half = note_hp(n);
                e_ten = (w < 12) ? 1 : 0;
            end else if (o == 8 + 16 * L) begin
                e_half = note_hp(L - 1);
                e_done = 1;
            end
        end
        chk("busy", int'(busy), e_busy);
        chk("amp_shdn", int'(shdn), e_shdn);
        chk("tone_en", int'(ten), e_ten);
        chk("done", int'(done), e_done);
        chk("half", int'(half), e_half);
        chk("amp_gain", int'(gain), 0);
    endtask

    task automatic step();
        model_edge(cyc + 1);
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic req(bit a, bit b);
        shr = a; sor = b;
        step();
        shr = 0; sor = 0;
    endtask

    initial begin
        #3;
        check_all();
        @(posedge clk); #1;
        check_all();
        #2 rst_n = 1'b1;
        enable = 1'b1;
        run(3);

        // Shuffle alone, then both at once (solve wins).
        req(1, 0); run(62);
        req(1, 1); run(78);

        // Solve preempts shuffle note 2 at edge 30.
        req(1, 0); run(29);
        req(0, 1); run(80);

        // Requests during solve playback are ignored.
        req(0, 1); run(20);
        req(1, 0); run(10);
        req(0, 1); run(8);
        req(1, 1); run(50);

        // Solve during shuffle wake switches melody only.
        req(1, 0); run(3);
        req(0, 1); run(80);

        // Disable during gap, request while disabled, then recover.
        req(1, 0); run(21);
        enable = 1'b0; step();
        req(1, 0); run(5);
        shr = 1'b1; enable = 1'b1; step(); shr = 1'b0;
        run(3);
        req(1, 0); run(62);

        // Asynchronous reset in the middle of a note.
        req(1, 0); run(12);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_tone_en", int'(ten), 0);
        chk("rst_amp_shdn", int'(shdn), 0);
        chk("rst_half", int'(half), 0);
        chk("rst_done", int'(done), 0);
        @(posedge clk); #1;
        #2 rst_n = 1'b1;
        act = 0; p_sh = 0; p_so = 0;
        run(4);

        // Random requests with occasional disables.
        for (int i = 0; i < 4000; i++) begin
            if (enable) enable = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            else enable = ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0;
            shr = ($urandom_range(0, 99) < 4) ? 1'b1 : 1'b0;
            sor = ($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0;
            step();
        end
        shr = 0; sor = 0; enable = 1'b1;
        run(100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
